// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code datapath: default width, decoder FSM states,
// and width-agnostic Gray/popcount helpers (callers zero-extend narrower values to 32 bits).
package gray_pkg;

    localparam int GRAY_WIDTH = 4;

    typedef enum logic [0:0] {
        EMPTY    = 1'b0,
        TRACKING = 1'b1
    } state_t;

    // Zero-extended inputs decode correctly: the leading zeros leave the low bits untouched.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Purely combinational WIDTH-bit Gray-to-binary decoder.
module gray2bin_comb #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Prefix-XOR from the MSB down.
    always_comb begin
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = gray_i[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ gray_i[i];
        end
        bin_o = b;
    end

endmodule

// File: rtl/gray_step_decoder.sv
// Gray receive stage: registered decode plus single-step legality, direction
// and wrap-around tracking against the previously accepted sample.
module gray_step_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH  = GRAY_WIDTH,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_gray,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_bin,
    output logic              dir_up,
    output logic              step_err,
    output logic              err_sticky,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam logic [WIDTH-1:0]  BIN_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]  BIN_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]  BIN_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   prev_gray_q, prev_gray_d;
    logic [WIDTH-1:0]   prev_bin_q, prev_bin_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_bin_q, out_bin_d;
    logic               dir_up_q, dir_up_d;
    logic               step_err_q, step_err_d;
    logic               err_sticky_q, err_sticky_d;
    logic [WRAP_W-1:0]  wrap_cnt_q, wrap_cnt_d;

    logic [WIDTH-1:0]   bin_s;
    logic [5:0]         hd_s;

    gray2bin_comb #(.WIDTH(WIDTH)) u_dec (
        .gray_i (in_gray),
        .bin_o  (bin_s)
    );

    assign hd_s = popcount(32'(in_gray ^ prev_gray_q));

    // Next-state: every accepted sample is decoded and becomes the new reference.
    always_comb begin
        state_d      = state_q;
        prev_gray_d  = prev_gray_q;
        prev_bin_d   = prev_bin_q;
        out_valid_d  = 1'b0;
        out_bin_d    = out_bin_q;
        dir_up_d     = dir_up_q;
        step_err_d   = 1'b0;
        err_sticky_d = err_sticky_q;
        wrap_cnt_d   = wrap_cnt_q;
        if (in_valid) begin
            out_valid_d = 1'b1;
            out_bin_d   = bin_s;
            prev_gray_d = in_gray;
            prev_bin_d  = bin_s;
            state_d     = TRACKING;
            case (state_q)
                EMPTY: begin
                    step_err_d = 1'b0;
                end
                TRACKING: begin
                    if (hd_s == 6'd0) begin
                        step_err_d = 1'b0;
                    end else if (hd_s == 6'd1) begin
                        dir_up_d = (bin_s == prev_bin_q + BIN_ONE);
                        if (prev_bin_q == BIN_MAX && bin_s == BIN_ZERO) begin
                            wrap_cnt_d = wrap_cnt_q + WRAP_ONE;
                        end else if (prev_bin_q == BIN_ZERO && bin_s == BIN_MAX) begin
                            wrap_cnt_d = wrap_cnt_q - WRAP_ONE;
                        end else begin
                            wrap_cnt_d = wrap_cnt_q;
                        end
                    end else begin
                        // Multi-bit jump: flag it, keep direction/wrap, resync on this sample.
                        step_err_d   = 1'b1;
                        err_sticky_d = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // State and registered outputs; reset drops any same-cycle sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            prev_gray_q  <= BIN_ZERO;
            prev_bin_q   <= BIN_ZERO;
            out_valid_q  <= 1'b0;
            out_bin_q    <= BIN_ZERO;
            dir_up_q     <= 1'b0;
            step_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            wrap_cnt_q   <= {WRAP_W{1'b0}};
        end else begin
            state_q      <= state_d;
            prev_gray_q  <= prev_gray_d;
            prev_bin_q   <= prev_bin_d;
            out_valid_q  <= out_valid_d;
            out_bin_q    <= out_bin_d;
            dir_up_q     <= dir_up_d;
            step_err_q   <= step_err_d;
            err_sticky_q <= err_sticky_d;
            wrap_cnt_q   <= wrap_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_bin    = out_bin_q;
    assign dir_up     = dir_up_q;
    assign step_err   = step_err_q;
    assign err_sticky = err_sticky_q;
    assign wrap_cnt   = wrap_cnt_q;

endmodule
